// File: rtl/qracc_pkg.sv
// Shared types and helpers for the partial-sum accumulator.
package qracc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_STALL = 2'd2
  } acc_state_t;

  localparam int unsigned ACC_BITS_DEF = 16;

  // Largest value representable in a signed field of the given width.
  function automatic int acc_max(input int unsigned bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  // Smallest value representable in a signed field of the given width.
  function automatic int acc_min(input int unsigned bits);
    return -(1 << (bits - 1));
  endfunction

  localparam int ACC_MAX = acc_max(ACC_BITS_DEF);
  localparam int ACC_MIN = acc_min(ACC_BITS_DEF);

endpackage

// File: rtl/qracc_col_acc.sv
// One accumulator lane: sign-extend ADC code, negate or shift-add, then
// saturate (QRACC_ACC_SATURATE_EN) or wrap, flagging any overflow.
module qracc_col_acc
  import qracc_pkg::*;
#(
  parameter int unsigned ADC_BITS = 4,
  parameter int unsigned ACC_BITS = 16
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       en,
  input  logic                       first,
  input  logic                       negate,
  input  logic                       last,
  input  logic signed [ADC_BITS-1:0] adc,
  output logic signed [ACC_BITS-1:0] sum_c,
  output logic                       ovf_c
);

  // Two guard bits cover 2*acc + s and -s without losing the true value.
  localparam int unsigned W = ACC_BITS + 2;
  localparam logic signed [W-1:0] MAX_W = W'(acc_max(ACC_BITS));
  localparam logic signed [W-1:0] MIN_W = W'(acc_min(ACC_BITS));

  logic signed [ACC_BITS-1:0] acc;
  logic signed [W-1:0]        s_w;
  logic signed [W-1:0]        acc_w;
  logic signed [W-1:0]        raw;

  // Next lane value for the plane being accepted.
  always_comb begin
    s_w   = W'(adc);
    acc_w = W'(acc);
    raw   = first ? (negate ? -s_w : s_w) : ((acc_w <<< 1) + s_w);
    ovf_c = (raw > MAX_W) || (raw < MIN_W);
`ifdef QRACC_ACC_SATURATE_EN
    if (ovf_c) sum_c = raw[W-1] ? ACC_BITS'(MIN_W) : ACC_BITS'(MAX_W);
    else       sum_c = raw[ACC_BITS-1:0];
`else
    sum_c = raw[ACC_BITS-1:0];
`endif
  end

  // Running sum; cleared once the batch result has been handed off.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)    acc <= '0;
    else if (en)  acc <= last ? '0 : sum_c;
  end

endmodule

// File: rtl/qracc_psum_accumulator.sv
// Bit-plane shift-add accumulator behind the ADC array.
// Optional feature macro: QRACC_ACC_SATURATE_EN (clamp lanes instead of wrap).
module qracc_psum_accumulator
  import qracc_pkg::*;
#(
  parameter int unsigned NUM_COLS    = 8,
  parameter int unsigned ADC_BITS    = 4,
  parameter int unsigned CFG_BITS    = 8,
  parameter int unsigned MAX_IN_BITS = 8,
  parameter int unsigned ACC_BITS    = 16
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [CFG_BITS-1:0]          n_input_bits_cfg,
  input  logic [NUM_COLS*ADC_BITS-1:0] adc_out_i,
  input  logic                         adc_valid_i,
  output logic                         adc_ready_o,
  output logic [NUM_COLS*ACC_BITS-1:0] out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         busy_o,
  output logic                         overflow_o
);

  localparam int unsigned CNT_W = $clog2(MAX_IN_BITS + 1);

  acc_state_t                  state, state_d;
  logic [CNT_W-1:0]            cnt, cnt_d;
  logic [CNT_W-1:0]            n_lat, n_lat_d;
  logic [CNT_W-1:0]            n_cfg, n_used, plane_idx;
  logic                        is_last, accept, load_out;
  logic [NUM_COLS*ACC_BITS-1:0] sum_vec;
  logic [NUM_COLS-1:0]          ovf_vec;

  // Sanitised plane count: 0 means 1, values above the maximum clamp.
  always_comb begin
    if (n_input_bits_cfg == '0)                           n_cfg = CNT_W'(1);
    else if (n_input_bits_cfg > CFG_BITS'(MAX_IN_BITS))   n_cfg = CNT_W'(MAX_IN_BITS);
    else                                                  n_cfg = CNT_W'(n_input_bits_cfg);
  end

  // Plane position and handshake; only a blocked last plane is refused.
  always_comb begin
    plane_idx   = (state == S_IDLE) ? '0 : cnt;
    n_used      = (state == S_IDLE) ? n_cfg : n_lat;
    is_last     = (plane_idx + CNT_W'(1)) == n_used;
    adc_ready_o = !(is_last && out_valid_o && !out_ready_i);
    accept      = adc_valid_i && adc_ready_o;
  end

  // Next-state and plane counter.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    n_lat_d  = n_lat;
    load_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          n_lat_d = n_cfg;
          if (is_last) begin
            load_out = 1'b1;
          end else begin
            state_d = S_ACCUM;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_ACCUM, S_STALL: begin
        if (accept) begin
          if (is_last) begin
            load_out = 1'b1;
            state_d  = S_IDLE;
            cnt_d    = '0;
          end else begin
            state_d  = S_ACCUM;
            cnt_d    = cnt + CNT_W'(1);
          end
        end else if (adc_valid_i && is_last) begin
          state_d = S_STALL;
        end else begin
          state_d = S_ACCUM;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      n_lat       <= CNT_W'(1);
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      n_lat  <= n_lat_d;
      busy_o <= (state_d != S_IDLE);
      if (load_out) begin
        out_data_o  <= sum_vec;
        out_valid_o <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      if (accept && (|ovf_vec)) overflow_o <= 1'b1;
    end
  end

  // One accumulator per ADC column.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
    qracc_col_acc #(
      .ADC_BITS (ADC_BITS),
      .ACC_BITS (ACC_BITS)
    ) u_lane (
      .clk    (clk),
      .nrst   (nrst),
      .en     (accept),
      .first  (plane_idx == '0),
      .negate (n_used != CNT_W'(1)),
      .last   (is_last),
      .adc    (adc_out_i[c*ADC_BITS +: ADC_BITS]),
      .sum_c  (sum_vec[c*ACC_BITS +: ACC_BITS]),
      .ovf_c  (ovf_vec[c])
    );
  end

endmodule

// File: tb/tb_qracc_psum_accumulator.sv
// Directed bench with a result scoreboard for qracc_psum_accumulator.
module tb_qracc_psum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nrst;
  logic [7:0]   cfg;
  logic [31:0]  adc;
  logic         adc_valid, adc_ready;
  logic [127:0] out_data;
  logic         out_valid, out_ready, busy, ovf;

  logic [7:0]   cfg6;
  logic [31:0]  adc6;
  logic         adc_valid6, adc_ready6;
  logic [47:0]  out_data6;
  logic         out_valid6, out_ready6, busy6, ovf6;

  int total = 0;
  int bad   = 0;
  logic [127:0] sb [$];

  qracc_psum_accumulator dut (
    .clk(clk), .nrst(nrst), .n_input_bits_cfg(cfg),
    .adc_out_i(adc), .adc_valid_i(adc_valid), .adc_ready_o(adc_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .overflow_o(ovf)
  );

  qracc_psum_accumulator #(.ACC_BITS(6)) dut6 (
    .clk(clk), .nrst(nrst), .n_input_bits_cfg(cfg6),
    .adc_out_i(adc6), .adc_valid_i(adc_valid6), .adc_ready_o(adc_ready6),
    .out_data_o(out_data6), .out_valid_o(out_valid6), .out_ready_i(out_ready6),
    .busy_o(busy6), .overflow_o(ovf6)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Weighted-sum reference: MSB plane carries negative weight when N>1.
  function automatic logic [127:0] model(input logic [31:0] p [8], input int n);
    logic [127:0] r;
    logic [31:0] w;
    logic signed [3:0] c4;
    int v, c, wt;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      v = 0;
      for (int k = 0; k < n; k++) begin
        w  = p[k];
        c4 = w[4*i +: 4];
        c  = c4;
        wt = 1 << (n - 1 - k);
        if (k == 0 && n > 1) v = v - c * wt;
        else                 v = v + c * wt;
      end
      r[16*i +: 16] = 16'(v);
    end
    return r;
  endfunction

  task automatic plane(input logic [31:0] codes);
    int guard;
    guard = 0;
    adc = codes;
    adc_valid = 1'b1;
    @(negedge clk);
    while (!adc_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      total++;
      bad++;
      $error("FAIL plane_timeout observed=ready0 expected=ready1");
    end
    @(posedge clk); #1;
    adc_valid = 1'b0;
  endtask

  task automatic plane6(input logic [31:0] codes);
    adc6 = codes;
    adc_valid6 = 1'b1;
    @(negedge clk);
    chk("plane6_ready", adc_ready6, 1);
    @(posedge clk); #1;
    adc_valid6 = 1'b0;
  endtask

  task automatic run_batch(input int n, input logic [31:0] p [8]);
    sb.push_back(model(p, n));
    cfg = 8'(n);
    for (int k = 0; k < n; k++) plane(p[k]);
  endtask

  // Every transfer on the output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (nrst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_output observed=%h expected=none", out_data);
      end else begin
        chk("sb_result", out_data, sb.pop_front());
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pa [8];
    logic [31:0] pb [8];
    logic [127:0] exp_a, exp_b;
    for (int i = 0; i < 8; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    nrst = 1'b0; cfg = 8'd1; adc = '0; adc_valid = 1'b0; out_ready = 1'b1;
    cfg6 = 8'd1; adc6 = '0; adc_valid6 = 1'b0; out_ready6 = 1'b1;
    repeat (2) @(posedge clk); #1;

    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_adc_ready", adc_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", ovf, 0);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;

    // N=1 pass-through, single-cycle valid pulse
    pa[0] = 32'h5F10_87E3;
    run_batch(1, pa);
    chk("n1_valid", out_valid, 1);
    chk("n1_data", out_data, 128'h0005_FFFF_0001_0000_FFF8_0007_FFFE_0003);
    @(posedge clk); #1;
    chk("n1_pulse_end", out_valid, 0);

    // N=4 with MSB negative weight
    pa[0] = 32'h0000_00F1; pa[1] = 32'h0000_00F0; pa[2] = 32'h0000_00F1; pa[3] = 32'h0000_00F1;
    sb.push_back(model(pa, 4));
    cfg = 8'd4;
    plane(pa[0]);
    chk("n4_busy_first", busy, 1);
    plane(pa[1]);
    plane(pa[2]);
    chk("n4_no_early_valid", out_valid, 0);
    plane(pa[3]);
    chk("n4_busy_done", busy, 0);
    chk("n4_lane0", out_data[15:0], 16'hFFFB);
    chk("n4_lane1", out_data[31:16], 16'h0001);
    @(posedge clk); #1;

    // Back-pressure: second batch's last plane waits for the held result
    out_ready = 1'b0;
    pa[0] = 32'h1234_5678; pa[1] = 32'h89AB_CDEF;
    pb[0] = 32'h7777_0000; pb[1] = 32'h0F0F_0F0F;
    exp_a = model(pa, 2);
    exp_b = model(pb, 2);
    run_batch(2, pa);
    chk("stall_a_valid", out_valid, 1);
    sb.push_back(exp_b);
    cfg = 8'd2;
    plane(pb[0]);
    chk("stall_busy", busy, 1);
    adc = pb[1];
    adc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready_low", adc_ready, 0);
      chk("stall_hold_data", out_data, exp_a);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", adc_ready, 1);
    @(posedge clk); #1;
    adc_valid = 1'b0;
    chk("stall_b_valid", out_valid, 1);
    chk("stall_b_data", out_data, exp_b);
    @(posedge clk); #1;
    chk("stall_drained", out_valid, 0);

    // Reset mid-batch discards held output and partial sums
    out_ready = 1'b0;
    cfg = 8'd1;
    plane(32'h1111_1111);
    cfg = 8'd4;
    plane(32'h7777_7777);
    plane(32'h7777_7777);
    chk("pre_rst_busy", busy, 1);
    nrst = 1'b0;
    #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_adc_ready", adc_ready, 1);
    @(negedge clk) nrst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    pa[0] = 32'hA5A5_A5A5; pa[1] = 32'h3C3C_3C3C; pa[2] = 32'h0FF0_0FF0; pa[3] = 32'h1248_1248;
    run_batch(4, pa);
    chk("fresh_data", out_data, model(pa, 4));

    // cfg 0 behaves as one plane
    pa[0] = 32'h7654_321F;
    sb.push_back(model(pa, 1));
    cfg = 8'd0;
    plane(pa[0]);
    chk("cfg0_valid", out_valid, 1);

    // cfg change mid-batch is ignored
    pa[0] = 32'h9182_7364; pa[1] = 32'h5A5A_1234; pa[2] = 32'hFEDC_BA98; pa[3] = 32'h0101_F0F0;
    sb.push_back(model(pa, 4));
    cfg = 8'd4;
    plane(pa[0]);
    cfg = 8'd2;
    plane(pa[1]);
    chk("cfg_mid_busy", busy, 1);
    chk("cfg_mid_no_valid", out_valid, 0);
    plane(pa[2]);
    plane(pa[3]);
    chk("cfg_mid_valid", out_valid, 1);

    // cfg above maximum clamps to 8 planes
    for (int k = 0; k < 8; k++) pb[k] = 32'h8F70_19E6 ^ (32'h1111_1111 * k);
    sb.push_back(model(pb, 8));
    cfg = 8'd200;
    for (int k = 0; k < 7; k++) plane(pb[k]);
    chk("clamp_busy", busy, 1);
    plane(pb[7]);
    chk("clamp_valid", out_valid, 1);

    // Back-to-back single-plane batches
    pa[0] = 32'h1357_9BDF; pa[1] = 32'h2468_ACE0;
    sb.push_back(model(pa, 1));
    pb[0] = pa[1];
    sb.push_back(model(pb, 1));
    cfg = 8'd1;
    plane(pa[0]);
    plane(pa[1]);
    chk("b2b_second", out_data, model(pb, 1));
    @(posedge clk); #1;

    // Narrow accumulator: in-range sum, then overflow
    cfg6 = 8'd4;
    for (int k = 0; k < 4; k++) plane6(32'h7777_7777);
    chk("acc6_sum", out_data6, 48'hE79E79E79E79);
    chk("acc6_no_ovf", ovf6, 0);
    cfg6 = 8'd6;
    plane6(32'h7777_7777);
    for (int k = 0; k < 5; k++) plane6(32'h8888_8888);
    chk("acc6_ovf", ovf6, 1);
`ifdef QRACC_ACC_SATURATE_EN
    chk("acc6_ovf_data", out_data6, 48'h820820820820);
`else
    chk("acc6_ovf_data", out_data6, 48'hA28A28A28A28);
`endif
    cfg6 = 8'd1;
    plane6(32'h0000_0000);
    chk("acc6_ovf_sticky", ovf6, 1);
    chk("acc16_no_ovf", ovf, 0);

    repeat (2) @(posedge clk); #1;
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
